uart_fifo_buf: RTL and testbench



---
 rtl/uart_fifo_pkg.sv | 16 +
 rtl/uart_fifo_ram.sv | 32 +++
 rtl/uart_fifo_buf.sv | 125 ++++++++++++
 tb/tb_uart_fifo_buf.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared defaults and status bundle for the UART FIFO buffer
package uart_fifo_pkg;

  localparam int UART_FIFO_DW    = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } fifo_status_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - register-file storage for the UART FIFO buffer
// Clocked write port with enable, combinational read port by address.
module uart_fifo_ram
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_FIFO_DW,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_buf.sv
// rtl/uart_fifo_buf.sv - parametrised UART TX/RX FIFO with flags, sticky errors and flush
// UART_FIFO_FWFT_EN selects first-word-fall-through read data; otherwise rdata is registered on pop.
module uart_fifo_buf
  import uart_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = UART_FIFO_DW,
  parameter int FIFO_DEPTH    = UART_FIFO_DEPTH,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int CNT_WIDTH     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_fifo_clk,
  input  logic                  i_fifo_rst_n,
  input  logic                  i_fifo_push,
  input  logic [DATA_WIDTH-1:0] i_fifo_wdata,
  input  logic                  i_fifo_pop,
  output logic [DATA_WIDTH-1:0] o_fifo_rdata,
  input  logic                  i_fifo_flush,
  input  logic                  i_fifo_clr_err,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_afull,
  output logic                  o_fifo_aempty,
  output logic [CNT_WIDTH-1:0]  o_fifo_count,
  output logic                  o_fifo_ovf,
  output logic                  o_fifo_udf
);

  localparam int AW = CNT_WIDTH - 1;
  localparam logic [CNT_WIDTH-1:0] AFULL_T  = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_T = CNT_WIDTH'(AEMPTY_THRESH);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_fifo_buf: FIFO_DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 0 || AFULL_THRESH > FIFO_DEPTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH) begin : g_bad_thresh
    $error("uart_fifo_buf: thresholds must lie in 0..FIFO_DEPTH");
  end

  logic [CNT_WIDTH-1:0]  wptr, rptr, count;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  full, empty, pop_ok, push_ok, ovf_q, udf_q;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop_ok  = i_fifo_pop && !empty;
    push_ok = i_fifo_push && (!full || pop_ok);
  end

  always_ff @(posedge i_fifo_clk or negedge i_fifo_rst_n) begin
    if (!i_fifo_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (i_fifo_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ONE;
      if (pop_ok)  rptr <= rptr + ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Flush swallows same-cycle requests, so they cannot raise errors either.
  always_ff @(posedge i_fifo_clk or negedge i_fifo_rst_n) begin
    if (!i_fifo_rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (i_fifo_clr_err) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!i_fifo_flush) begin
      if (i_fifo_push && full && !pop_ok) ovf_q <= 1'b1;
      if (i_fifo_pop && empty)            udf_q <= 1'b1;
    end
  end

  uart_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (i_fifo_clk),
    .rst_n (i_fifo_rst_n),
    .we    (push_ok && !i_fifo_flush),
    .waddr (wptr[AW-1:0]),
    .wdata (i_fifo_wdata),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_rdata)
  );

`ifdef UART_FIFO_FWFT_EN
  assign o_fifo_rdata = ram_rdata;
`else
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge i_fifo_clk or negedge i_fifo_rst_n) begin
    if (!i_fifo_rst_n) begin
      rdata_q <= '0;
    end else if (pop_ok && !i_fifo_flush) begin
      rdata_q <= ram_rdata;
    end
  end

  assign o_fifo_rdata = rdata_q;
`endif

  assign o_fifo_full   = full;
  assign o_fifo_empty  = empty;
  assign o_fifo_afull  = (count >= AFULL_T);
  assign o_fifo_aempty = (count <= AEMPTY_T);
  assign o_fifo_count  = count;
  assign o_fifo_ovf    = ovf_q;
  assign o_fifo_udf    = udf_q;

endmodule

// File: tb/tb_uart_fifo_buf.sv
// tb/tb_uart_fifo_buf.sv - directed self-checking bench for uart_fifo_buf
// Handles both read modes; define UART_FIFO_FWFT_EN for the FWFT build.
module tb_uart_fifo_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       push = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       pop = 1'b0;
  logic [7:0] rdata;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       full, empty, afull, aempty, ovf, udf;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_fifo_buf dut (
    .i_fifo_clk     (clk),
    .i_fifo_rst_n   (rst_n),
    .i_fifo_push    (push),
    .i_fifo_wdata   (wdata),
    .i_fifo_pop     (pop),
    .o_fifo_rdata   (rdata),
    .i_fifo_flush   (flush),
    .i_fifo_clr_err (clr_err),
    .o_fifo_full    (full),
    .o_fifo_empty   (empty),
    .o_fifo_afull   (afull),
    .o_fifo_aempty  (aempty),
    .o_fifo_count   (count),
    .o_fifo_ovf     (ovf),
    .o_fifo_udf     (udf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    push = 1'b1;
    wdata = d;
    tick();
    push = 1'b0;
  endtask

  // Returns the word a pop consumes, sampled where each read mode presents it.
  task automatic pop_word(output logic [7:0] got);
`ifdef UART_FIFO_FWFT_EN
    got = rdata;
    pop = 1'b1;
    tick();
    pop = 1'b0;
`else
    pop = 1'b1;
    tick();
    pop = 1'b0;
    got = rdata;
`endif
  endtask

  task automatic push_pop(input logic [7:0] d, output logic [7:0] got);
    push = 1'b1;
    wdata = d;
`ifdef UART_FIFO_FWFT_EN
    got = rdata;
    pop = 1'b1;
    tick();
`else
    pop = 1'b1;
    tick();
    got = rdata;
`endif
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    n_checks++;
    if ({empty, aempty, full, afull, ovf, udf} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 110000", {empty, aempty, full, afull, ovf, udf});
    end
    n_checks++;
    if (count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    n_checks++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 00", rdata);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] got;
    for (int i = 0; i < 16; i++) begin
      push_word(8'(i));
      n_checks++;
      if (count !== 5'(i + 1) || afull !== (i + 1 >= 14) || full !== (i == 15) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: count=%0d afull=%b full=%b empty=%b expected count=%0d afull=%b full=%b empty=0",
                 i, count, afull, full, empty, i + 1, (i + 1 >= 14), (i == 15));
      end
    end
    for (int i = 0; i < 16; i++) begin
      pop_word(got);
      n_checks++;
      if (got !== 8'(i) || count !== 5'(15 - i) || aempty !== (15 - i <= 2)) begin
        n_fail++;
        $display("FAIL drain_%0d: data=%h count=%0d aempty=%b expected data=%h count=%0d aempty=%b",
                 i, got, count, aempty, 8'(i), 15 - i, (15 - i <= 2));
      end
    end
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: empty=%b full=%b expected empty=1 full=0", empty, full);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    push_word(8'hAA);
    n_checks++;
    if (count !== 5'd16 || ovf !== 1'b1 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: count=%0d ovf=%b full=%b expected 16 1 1", count, ovf, full);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", ovf);
    end
    for (int i = 0; i < 16; i++) begin
      pop_word(got);
      n_checks++;
      if (got !== 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_drain_%0d: got %h expected %h", i, got, 8'(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) push_word(8'h10 + 8'(i));
    for (int k = 0; k < 32; k++) begin
      push_pop((k == 31) ? 8'h55 : 8'h60 + 8'(k), got);
      exp = (k < 16) ? 8'h10 + 8'(k) : 8'h60 + 8'(k - 16);
      n_checks++;
      if (got !== exp || count !== 5'd16 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_%0d: data=%h count=%0d ovf=%b expected data=%h count=16 ovf=0",
                 k, got, count, ovf, exp);
      end
    end
    for (int i = 0; i < 16; i++) begin
      pop_word(got);
      exp = (i == 15) ? 8'h55 : 8'h70 + 8'(i);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_drain_%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] got;
    push = 1'b1;
    wdata = 8'h33;
    pop = 1'b1;
    tick();
    push = 1'b0;
    pop = 1'b0;
    n_checks++;
    if (udf !== 1'b1 || count !== 5'd1 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_set: udf=%b count=%0d empty=%b expected 1 1 0", udf, count, empty);
    end
`ifndef UART_FIFO_FWFT_EN
    n_checks++;
    if (rdata !== 8'h55) begin
      n_fail++;
      $display("FAIL udf_rdata_hold: got %h expected 55", rdata);
    end
`endif
    pop_word(got);
    n_checks++;
    if (got !== 8'h33) begin
      n_fail++;
      $display("FAIL udf_read: got %h expected 33", got);
    end
    pop = 1'b1;
    clr_err = 1'b1;
    tick();
    pop = 1'b0;
    clr_err = 1'b0;
    n_checks++;
    if (udf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err_wins: udf=%b expected 0", udf);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] got;
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    n_checks++;
    if (count !== 5'd5) begin
      n_fail++;
      $display("FAIL flush_pre_count: got %0d expected 5", count);
    end
    flush = 1'b1;
    push = 1'b1;
    wdata = 8'h99;
    tick();
    flush = 1'b0;
    push = 1'b0;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || ovf !== 1'b0 || udf !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: count=%0d empty=%b ovf=%b udf=%b expected 0 1 0 1", count, empty, ovf, udf);
    end
`ifndef UART_FIFO_FWFT_EN
    n_checks++;
    if (rdata !== 8'h33) begin
      n_fail++;
      $display("FAIL flush_rdata_hold: got %h expected 33", rdata);
    end
`endif
    push_word(8'h77);
    pop_word(got);
    n_checks++;
    if (got !== 8'h77 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after: data=%h empty=%b expected 77 1", got, empty);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_latency();
    push_word(8'hC3);
`ifdef UART_FIFO_FWFT_EN
    n_checks++;
    if (rdata !== 8'hC3) begin
      n_fail++;
      $display("FAIL fwft_latency: got %h expected c3", rdata);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
`else
    n_checks++;
    if (rdata !== 8'h77) begin
      n_fail++;
      $display("FAIL reg_before_pop: got %h expected 77", rdata);
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    n_checks++;
    if (rdata !== 8'hC3) begin
      n_fail++;
      $display("FAIL reg_after_pop: got %h expected c3", rdata);
    end
`endif
  endtask

  task automatic test_async_reset();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    push_word(8'hE1);
    push_word(8'hE2);
    push_word(8'hE3);
    n_checks++;
    if (count !== 5'd3 || udf !== 1'b1 || rdata === 8'h00) begin
      n_fail++;
      $display("FAIL pre_reset: count=%0d udf=%b rdata=%h expected 3 1 nonzero", count, udf, rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (count !== 5'd0 || {empty, aempty, full, afull, ovf, udf} !== 6'b110000 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d flags=%b rdata=%h expected 0 110000 00",
               count, {empty, aempty, full, afull, ovf, udf}, rdata);
    end
    #2 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_flush();
    test_latency();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
